// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the RV32IM single-cycle core: owns the PC,
// selects the next fetch address and turns misaligned control transfers into traps.
module pc_sequencer #(
   parameter int                  PC_WIDTH     = 32,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int                  CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 imem_ready,
   input  logic                 stall_req,
   input  logic                 jump_en,
   input  logic [PC_WIDTH-1:0]  jump_target,
   input  logic                 branch_taken,
   input  logic [PC_WIDTH-1:0]  branch_target,
   output logic [PC_WIDTH-1:0]  pc,
   output logic [PC_WIDTH-1:0]  pc_plus_4,
   output logic                 imem_req,
   output logic                 retire,
   output logic                 redirect,
   output logic                 trap_valid,
   output logic [PC_WIDTH-1:0]  trap_epc,
   output logic [PC_WIDTH-1:0]  trap_tval,
   output logic [CNT_WIDTH-1:0] stall_cycles
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      TRAP = 2'd2
   } seqState_e;

   seqState_e             state_q, state_d;
   logic [PC_WIDTH-1:0]   pc_q, pc_d;
   logic [PC_WIDTH-1:0]   epc_q, epc_d;
   logic [PC_WIDTH-1:0]   tval_q, tval_d;
   logic [CNT_WIDTH-1:0]  stall_q, stall_d;

   logic                  advance;
   logic                  ctrlSel;
   logic                  misaligned;
   logic [PC_WIDTH-1:0]   targetSel;

   assign pc_plus_4 = pc_q + PC_WIDTH'(4);

   // Only jump/branch targets can be misaligned; the sequential path never traps.
   always_comb begin
      ctrlSel   = 1'b0;
      targetSel = pc_plus_4;
      if (jump_en) begin
         ctrlSel   = 1'b1;
         targetSel = jump_target;
      end else if (branch_taken) begin
         ctrlSel   = 1'b1;
         targetSel = branch_target;
      end
   end

   assign misaligned = ctrlSel && (targetSel[1:0] != 2'b00);
   assign advance    = (state_q == RUN) && imem_ready && !stall_req;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      epc_d    = epc_q;
      tval_d   = tval_q;
      stall_d  = stall_q;
      imem_req = 1'b0;
      retire   = 1'b0;
      redirect = 1'b0;
      case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            imem_req = 1'b1;
            if (!advance) begin
               if (!(&stall_q)) begin
                  stall_d = stall_q + 1'b1;
               end
            end else if (misaligned) begin
               epc_d   = pc_q;
               tval_d  = targetSel;
               state_d = TRAP;
            end else begin
               retire   = 1'b1;
               redirect = ctrlSel;
               pc_d     = targetSel;
            end
         end
         TRAP: begin
            redirect = 1'b1;
            pc_d     = TRAP_VECTOR;
            state_d  = RUN;
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_VECTOR;
         epc_q   <= '0;
         tval_q  <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         epc_q   <= epc_d;
         tval_q  <= tval_d;
         stall_q <= stall_d;
      end
   end

   assign pc           = pc_q;
   assign trap_valid   = (state_q == TRAP);
   assign trap_epc     = epc_q;
   assign trap_tval    = tval_q;
   assign stall_cycles = stall_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the RV32IM single-cycle core. It owns the architectural PC register and decides each cycle whether the PC advances to PC+4, to a jump target, or to a branch target. It holds the PC while instruction memory or a multi-cycle M-extension unit stalls. It converts misaligned control-transfer targets into a two-step trap sequence that redirects fetch to a fixed trap vector. It sits between the jump target generator, branch comparator, divider stall line and the instruction memory port.

## Interface
- PC_WIDTH, 32, width of PC and all target buses
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on misaligned-target trap
- CNT_WIDTH, 16, width of stall performance counter
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_ready  in  1  instruction at pc is valid this cycle
- stall_req  in  1  multi-cycle unit busy; current instruction must not retire
- jump_en  in  1  current instruction is JAL/JALR
- jump_target  in  PC_WIDTH  target from jump target generator (bit 0 already cleared)
- branch_taken  in  1  current conditional branch resolved taken
- branch_target  in  PC_WIDTH  PC+imm branch target
- pc  out  PC_WIDTH  registered fetch address
- pc_plus_4  out  PC_WIDTH  pc + 4, combinational, wraps modulo 2^PC_WIDTH
- imem_req  out  1  fetch request, high in RUN only
- retire  out  1  current instruction commits this cycle (combinational)
- redirect  out  1  pulse: PC loaded from jump/branch/trap target this edge
- trap_valid  out  1  registered, high exactly during TRAP state
- trap_epc  out  PC_WIDTH  PC of faulting instruction
- trap_tval  out  PC_WIDTH  offending misaligned target
- stall_cycles  out  CNT_WIDTH  saturating count of non-advancing RUN cycles

## Operation
- States: BOOT, RUN, TRAP.
- BOOT: entered on reset. pc = RESET_VECTOR, imem_req = 0, retire = 0. Next state is unconditionally RUN.
- RUN:
  - imem_req = 1.
  - advance = imem_ready & ~stall_req.
  - If advance is 0: pc holds, retire = 0, all jump/branch inputs are ignored, stall_cycles increments (saturating at all-ones).
  - If advance is 1: compute target selection with priority jump_en > branch_taken > sequential.
  - Chosen target is jump_target, branch_target or pc_plus_4.
  - Misaligned means target[1:0] != 2'b00. It applies to jump/branch targets only; pc_plus_4 is never checked.
  - Aligned case: retire = 1, pc <= target. redirect = 1 if target came from jump or branch, even when equal to pc_plus_4.
  - Misaligned case: retire = 0, pc holds, trap_epc <= pc, trap_tval <= target, next state TRAP.
- TRAP:
  - trap_valid = 1, imem_req = 0, retire = 0.
  - On exit edge: pc <= TRAP_VECTOR, redirect = 1 that cycle, next state RUN.
  - stall_req and imem_ready are ignored in TRAP.
- trap_epc and trap_tval hold their last values until the next trap; they are not cleared on exit.
- stall_cycles is cleared only by reset. It does not count BOOT or TRAP cycles.

## Timing
- Reset values (asynchronous, immediate): state BOOT, pc = RESET_VECTOR, trap_valid = 0, trap_epc = 0, trap_tval = 0, stall_cycles = 0.
- Because pc = RESET_VECTOR in reset, pc_plus_4 = RESET_VECTOR+4.
- Combinational outputs in reset: imem_req = 0, retire = 0, redirect = 0.
- First fetch: imem_req rises one cycle after rst_n deasserts (BOOT lasts exactly 1 cycle).
- Sequential advance: pc updates on the edge ending a cycle in which retire = 1. Zero-bubble throughput is 1 instruction/cycle.
- Trap latency: misaligned cycle (N) -> TRAP (N+1) -> pc = TRAP_VECTOR and RUN at N+2. The first fetch at TRAP_VECTOR occurs in cycle N+2.
- retire and redirect are combinational from the current state and inputs. pc, state, trap_* and stall_cycles are registered.
- rst_n assertion mid-RUN or mid-TRAP aborts immediately. No trap is reported, and trap_epc/tval clear.
- pc + 4 at 32'hFFFF_FFFC wraps to 32'h0000_0000 with no trap.

## Test plan
- Reset/boot: hold rst_n=0 then release, imem_ready=1 -> cycle 0 BOOT with imem_req=0, pc=0x0; cycle 1 imem_req=1; pc sequence 0x0, 0x4, 0x8 on successive edges with retire=1.
- Stall: at pc=0x10, assert stall_req for 5 cycles with jump_en=1, jump_target=0x80 -> pc stays 0x10, retire=0, stall_cycles=5; first non-stalled cycle with jump_en=1 -> redirect=1, pc=0x80.
- Priority: jump_en=1 (0x40) and branch_taken=1 (0x200) in the same advancing cycle -> pc=0x40. branch_taken alone with branch_target=0x200 -> pc=0x200, redirect=1.
- Misaligned trap: pc=0x24, jump_en=1, jump_target=0x102 -> retire=0; next cycle trap_valid=1, trap_epc=0x24, trap_tval=0x102; following cycle pc=0x100, imem_req=1.
- Wrap and saturation: pc=0xFFFF_FFFC sequential advance -> pc=0x0, no trap. Force 70000 stall cycles with CNT_WIDTH=16 -> stall_cycles=0xFFFF.
- Reset mid-trap: assert rst_n=0 during TRAP -> trap_valid=0, pc=RESET_VECTOR immediately; after release the BOOT-then-RUN sequence repeats.
